// File: rtl/fetch_unit24_pkg.sv
// fetch_unit24_pkg: shared ISA constants and fetch queue entry type
package fetch_unit24_pkg;
  localparam int PC_W = 24;
  localparam int ISA_W = 24;
  localparam logic [3:0] OPC_HALT = 4'h0;
  localparam logic [3:0] OPC_BEQ = 4'h7;
  localparam logic [3:0] OPC_JMP = 4'h8;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = '0;
  typedef struct packed {
    logic [ISA_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit24_if.sv
// fetch_unit24_if: imem, control and decode-side signals; master=fetch unit, slave=environment
interface fetch_unit24_if;
  import fetch_unit24_pkg::*;
  logic imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [ISA_W-1:0] imem_rdata;
  logic redirect;
  logic [PC_W-1:0] redirect_pc;
  logic halt_req;
  logic out_valid;
  logic out_ready;
  logic [ISA_W-1:0] out_instr;
  logic [PC_W-1:0] out_pc;
  logic halted;
  modport master (output imem_en, imem_addr, out_valid, out_instr, out_pc, halted,
                  input imem_rdata, redirect, redirect_pc, halt_req, out_ready);
  modport slave (input imem_en, imem_addr, out_valid, out_instr, out_pc, halted,
                 output imem_rdata, redirect, redirect_pc, halt_req, out_ready);
endinterface

// File: rtl/fetch_unit24_fifo2.sv
// fetch_unit24_fifo2: 2-entry {instr,pc} queue; ports i_flush/i_push/i_pop/i_data in, o_head/o_count out
module fetch_unit24_fifo2 import fetch_unit24_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);
  fetch_entry_t r_mem [2];
  logic [1:0] r_cnt;
  logic w_wi;
  // head always lives in slot 0; a push lands in the first slot left free after any pop
  assign w_wi = r_cnt[0] ^ i_pop;
  assign o_head = r_mem[0];
  assign o_count = r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_flush) r_cnt <= '0;
    else r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    if (i_pop) r_mem[0] <= r_mem[1];
    if (i_push) r_mem[w_wi] <= i_data;
  end
endmodule

// File: rtl/fetch_unit24.sv
// fetch_unit24: PC/issue logic, 1-cycle imem return, 2-entry output queue, redirect and halt; ports clk, rst, bus (master)
module fetch_unit24 import fetch_unit24_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic clk,
  input logic rst,
  fetch_unit24_if.master bus
);
  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;
  logic [0:0] r_state;
  logic [PC_W-1:0] r_pc, r_tag;
  logic r_inflight;
  logic [1:0] w_cnt;
  fetch_entry_t w_head;
  logic w_run, w_flush, w_issue, w_pop, w_push;
  assign w_run = r_state == S_RUN;
  assign w_flush = bus.redirect || bus.halt_req;
  // credit: queued + in-flight may never exceed the queue depth, so a return always fits
  assign w_issue = !rst && w_run && !w_flush && (w_cnt + {1'b0, r_inflight}) < 2'd2;
  // an arriving word bypasses the empty queue so it is visible the cycle it returns
  assign bus.out_valid = w_cnt != 2'd0 || r_inflight;
  assign bus.out_instr = w_cnt != 2'd0 ? w_head.instr : r_inflight ? bus.imem_rdata : '0;
  assign bus.out_pc = w_cnt != 2'd0 ? w_head.pc : r_inflight ? r_tag : '0;
  assign w_pop = bus.out_valid && bus.out_ready;
  assign w_push = r_inflight && !(w_cnt == 2'd0 && w_pop);
  assign bus.imem_en = w_issue;
  assign bus.imem_addr = r_pc;
  assign bus.halted = r_state == S_HALTED;
  fetch_unit24_fifo2 u_fifo (
    .clk(clk),
    .rst(rst),
    .i_flush(w_flush),
    .i_push(w_push),
    .i_pop(w_pop && w_cnt != 2'd0),
    .i_data({bus.imem_rdata, r_tag}),
    .o_head(w_head),
    .o_count(w_cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc <= RESET_PC;
      r_tag <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (bus.halt_req) r_state <= S_HALTED;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= r_pc;
        r_pc <= r_pc + 1'b1;
      end else if (bus.redirect && !bus.halt_req && w_run) r_pc <= bus.redirect_pc;
    end
  end
endmodule
